muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer_pkg.sv | 31 +++
 rtl/muldiv_iter_dp.sv | 40 ++++
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 codes, FSM
// encodings, special operand values and signedness decode helpers.
package muldiv_sequencer_pkg;

  localparam logic [2:0] MUL_F    = 3'b000;
  localparam logic [2:0] MULH_F   = 3'b001;
  localparam logic [2:0] MULHSU_F = 3'b010;
  localparam logic [2:0] MULHU_F  = 3'b011;
  localparam logic [2:0] DIV_F    = 3'b100;
  localparam logic [2:0] DIVU_F   = 3'b101;
  localparam logic [2:0] REM_F    = 3'b110;
  localparam logic [2:0] REMU_F   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic op1_is_signed(input logic [2:0] f3);
    return (f3 == MUL_F) || (f3 == MULH_F) || (f3 == MULHSU_F) ||
           (f3 == DIV_F) || (f3 == REM_F);
  endfunction

  function automatic logic op2_is_signed(input logic [2:0] f3);
    return (f3 == MUL_F) || (f3 == MULH_F) || (f3 == DIV_F) || (f3 == REM_F);
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Combinational single-iteration datapath: one shift-add multiply step (LSB
// first) or one restoring-division step (MSB first) over the shared accumulator.
module muldiv_iter_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   rem,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   rem_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: acc = {partial product hi, remaining multiplier bits}.
  // Divide:   acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    shifted  = {rem, acc[WIDTH-1]};
    diff     = shifted - {1'b0, mcand};
    acc_next = acc;
    rem_next = rem;
    if (is_div) begin
      // Partial remainder stays below the divisor, so a clear diff MSB means no borrow.
      if (!diff[WIDTH]) begin
        rem_next = diff[WIDTH-1:0];
        acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
      end else begin
        rem_next = shifted[WIDTH-1:0];
        acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: one bit per cycle, holds the pipeline
// through stall, abandons work on kill, and short-circuits divide corner cases.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             kill,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx;
  logic [WIDTH-1:0]   rem_q, rem_d, rem_nx;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               in_sa, in_sb, in_div, div_zero, div_ovf;
  logic [WIDTH-1:0]   a_abs, b_abs, fast_res, fix_res, quo_f, rem_f;
  logic [2*WIDTH-1:0] prod_f;

  muldiv_iter_dp #(.WIDTH(WIDTH)) u_iter_dp (
    .is_div   (f3_q[2]),
    .acc      (acc_q),
    .rem      (rem_q),
    .mcand    (mcand_q),
    .acc_next (acc_nx),
    .rem_next (rem_nx)
  );

  always_comb begin
    in_sa    = op1_is_signed(funct3) && op1[WIDTH-1];
    in_sb    = op2_is_signed(funct3) && op2[WIDTH-1];
    a_abs    = in_sa ? -op1 : op1;
    b_abs    = in_sb ? -op2 : op2;
    in_div   = funct3[2];
    div_zero = in_div && (op2 == '0);
    div_ovf  = ((funct3 == DIV_F) || (funct3 == REM_F)) && (op1 == INT_MIN) &&
               (op2 == ALL_ONES);
    if (div_zero) fast_res = funct3[1] ? op1 : ALL_ONES;
    else          fast_res = funct3[1] ? '0 : INT_MIN;
  end

  // Sign flags are only ever set for signed operands, so unsigned ops pass through.
  always_comb begin
    prod_f  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_f   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_f   = sa_q ? -rem_q : rem_q;
    fix_res = '0;
    unique case (f3_q)
      MUL_F:                      fix_res = prod_f[WIDTH-1:0];
      MULH_F, MULHSU_F, MULHU_F:  fix_res = prod_f[2*WIDTH-1:WIDTH];
      DIV_F, DIVU_F:              fix_res = quo_f;
      REM_F, REMU_F:              fix_res = rem_f;
      default:                    fix_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          f3_d = funct3;
          sa_d = in_sa;
          sb_d = in_sb;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = '0;
            rem_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
            mcand_d = in_div ? b_abs : a_abs;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign stall  = ((state_q == S_IDLE) && start && !kill) || busy;

endmodule
